// File: rtl/formal_upsizer.sv
// Stream width upsizer: packs IW-bit beats into RATIO-lane words with a lane keep
// mask and last flag. A beat carrying s_last closes the current word early.
module formal_upsizer #(
    parameter int IW    = 32,
    parameter int RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IW-1:0]         s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IW*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]      m_keep,
    output logic                  m_last
);

    localparam int OW = IW * RATIO;
    localparam int AW = IW * (RATIO - 1);
    localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;

    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [OW-1:0]    r_m_data;
    logic [RATIO-1:0] r_m_keep;
    logic             r_m_last;
    logic             r_m_valid;

    logic             w_accept;
    logic             w_close;
    logic [OW-1:0]    w_acc_ext;
    logic [OW-1:0]    w_word;
    logic [RATIO-1:0] w_keep;
    logic [AW-1:0]    w_acc_next;

    // Ready only depends on the output register and reset, never on s_valid.
    assign s_ready   = !rst && (!r_m_valid || m_ready);
    assign w_accept  = s_valid && s_ready;
    assign w_close   = w_accept && ((r_cnt == CW'(RATIO - 1)) || s_last);
    assign w_acc_ext = {{IW{1'b0}}, r_acc};

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_last  = r_m_last;

    // Assemble the candidate output word and the next accumulator contents.
    always_comb begin
        w_word     = '0;
        w_keep     = '0;
        w_acc_next = r_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) < r_cnt) begin
                w_word[k*IW +: IW] = w_acc_ext[k*IW +: IW];
                w_keep[k]          = 1'b1;
            end else if (CW'(k) == r_cnt) begin
                w_word[k*IW +: IW] = s_data;
                w_keep[k]          = 1'b1;
            end else begin
                w_word[k*IW +: IW] = {IW{1'b0}};
                w_keep[k]          = 1'b0;
            end
        end
        for (int k = 0; k < RATIO - 1; k++) begin
            if (w_accept && !w_close && (CW'(k) == r_cnt)) begin
                w_acc_next[k*IW +: IW] = s_data;
            end else begin
                w_acc_next[k*IW +: IW] = r_acc[k*IW +: IW];
            end
        end
    end

    // Lane counter and accumulator; both clear whenever a word closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
            r_acc <= {AW{1'b0}};
        end else if (w_close) begin
            r_cnt <= {CW{1'b0}};
            r_acc <= {AW{1'b0}};
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc_next;
        end else begin
            r_cnt <= r_cnt;
            r_acc <= r_acc;
        end
    end

    // Output register: a close replaces the word (even mid-drain); a drain only drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= {OW{1'b0}};
            r_m_keep  <= {RATIO{1'b0}};
            r_m_last  <= 1'b0;
        end else if (w_close) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_word;
            r_m_keep  <= w_keep;
            r_m_last  <= s_last;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_data  <= r_m_data;
            r_m_keep  <= r_m_keep;
            r_m_last  <= r_m_last;
        end else begin
            r_m_valid <= r_m_valid;
            r_m_data  <= r_m_data;
            r_m_keep  <= r_m_keep;
            r_m_last  <= r_m_last;
        end
    end

endmodule

// File: tb/tb_formal_upsizer.sv
// Directed bench for formal_upsizer (IW=32, RATIO=4) with hand-computed expected words.
module tb_formal_upsizer;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [3:0]   m_keep;
    logic         m_last;

    int errors;
    int checks;
    logic [127:0] exp_w;

    formal_upsizer #(.IW(32), .RATIO(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_keep (m_keep),
        .m_last (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 128'h0);
        check("rst_keep", m_keep, 4'h0);
        check("rst_last", m_last, 1'b0);
        check("rst_sready", s_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_sready", s_ready, 1'b1);

        // Full four-beat message
        beat(32'h11111111, 1'b0);
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b0);
        beat(32'h44444444, 1'b1);
        check("t1_valid", m_valid, 1'b1);
        check("t1_data", m_data, 128'h44444444_33333333_22222222_11111111);
        check("t1_keep", m_keep, 4'hF);
        check("t1_last", m_last, 1'b1);
        s_valid = 1'b0;
        tick();
        check("t1_drain_valid", m_valid, 1'b0);
        check("t1_drain_hold", m_data, 128'h44444444_33333333_22222222_11111111);

        // Two-beat short message
        beat(32'h0000000A, 1'b0);
        beat(32'h0000000B, 1'b1);
        check("t2_data", m_data, 128'h00000000_00000000_0000000B_0000000A);
        check("t2_keep", m_keep, 4'h3);
        check("t2_last", m_last, 1'b1);

        // Single-beat message arriving while the previous word drains
        beat(32'hDEADBEEF, 1'b1);
        check("t3_valid", m_valid, 1'b1);
        check("t3_data", m_data, 128'h00000000_00000000_00000000_DEADBEEF);
        check("t3_keep", m_keep, 4'h1);
        check("t3_last", m_last, 1'b1);
        s_valid = 1'b0;
        tick();

        // Eight beats with downstream stalled after the first word
        for (int i = 0; i < 4; i++) beat(32'hA0000001 + i, 1'b0);
        check("t4_w1_valid", m_valid, 1'b1);
        check("t4_w1_data", m_data, 128'hA0000004_A0000003_A0000002_A0000001);
        check("t4_w1_last", m_last, 1'b0);
        m_ready = 1'b0;
        s_data  = 32'hA0000005;
        s_last  = 1'b0;
        #1;
        check("t4_stall_sready", s_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", m_valid, 1'b1);
            check("t4_hold_data", m_data, 128'hA0000004_A0000003_A0000002_A0000001);
            check("t4_hold_sready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        #1;
        check("t4_resume_sready", s_ready, 1'b1);
        beat(32'hA0000005, 1'b0);
        check("t4_drained", m_valid, 1'b0);
        beat(32'hA0000006, 1'b0);
        beat(32'hA0000007, 1'b0);
        beat(32'hA0000008, 1'b1);
        check("t4_w2_valid", m_valid, 1'b1);
        check("t4_w2_data", m_data, 128'hA0000008_A0000007_A0000006_A0000005);
        check("t4_w2_keep", m_keep, 4'hF);
        check("t4_w2_last", m_last, 1'b1);
        s_valid = 1'b0;
        tick();

        // Full-rate streaming of twelve beats
        exp_w = 128'h0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h50000000 + i;
            s_last  = (i == 11);
            exp_w[(i % 4)*32 +: 32] = 32'h50000000 + i;
            #1;
            check("t5_sready", s_ready, 1'b1);
            tick();
            if ((i % 4) == 3) begin
                check("t5_valid", m_valid, 1'b1);
                check("t5_keep", m_keep, 4'hF);
                check("t5_data", m_data, exp_w);
                check("t5_last", m_last, (i == 11));
            end
        end
        s_valid = 1'b0;
        tick();

        // Reset in the middle of a message discards the partial beats
        beat(32'hBAD00000, 1'b0);
        beat(32'hBAD00001, 1'b0);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hBAD00002;
        #1;
        check("t6_rst_sready", s_ready, 1'b0);
        tick();
        check("t6_rst_valid", m_valid, 1'b0);
        check("t6_rst_data", m_data, 128'h0);
        check("t6_rst_keep", m_keep, 4'h0);
        check("t6_rst_last", m_last, 1'b0);
        rst = 1'b0;
        beat(32'h000000C0, 1'b0);
        beat(32'h000000C1, 1'b0);
        beat(32'h000000C2, 1'b0);
        beat(32'h000000C3, 1'b1);
        check("t6_valid", m_valid, 1'b1);
        check("t6_data", m_data, 128'h000000C3_000000C2_000000C1_000000C0);
        check("t6_keep", m_keep, 4'hF);
        check("t6_last", m_last, 1'b1);
        s_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/formal_upsizer.md
Name: formal_upsizer

Overview:
- Stream width upsizer for the formal selftest harness; sits directly downstream of the formal FIFO and consumes its narrow m_ stream.
- Packs IW-bit beats into RATIO-lane words of IW*RATIO bits, so FIFO-buffered reference words reach the cipher core at its block width.
- A beat with s_last closes a word early. The emitted word carries a lane keep mask and a last flag.

Parameters:
- IW, 32, input beat width in bits.
- RATIO, 4, lanes per output word; must be >= 2. Output width is IW*RATIO.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  IW  input beat payload.
- s_last  input  1  beat is the final beat of a message.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  IW*RATIO  packed word; lane k is bits [k*IW +: IW].
- m_keep  output  RATIO  lane valid mask; bit k set means lane k holds data.
- m_last  output  1  word contains the message's final beat.

Behaviour:
- Handshake is AXI-stream style.
  - A transfer occurs on a cycle with valid && ready.
  - m_valid must not drop, and m_data/m_keep/m_last must not change, while m_valid && !m_ready.
  - m_valid must not depend combinationally on m_ready.
- Reset (rst=1 at a clock edge) sets m_valid=0, m_data=0, m_keep=0, m_last=0, lane counter cnt=0 and accumulator=0.
  - Any partial word or pending output is discarded.
  - No transfers occur on a cycle with rst=1; s_ready=0 while rst=1.
- State:
  - cnt counts 0..RATIO-1 and is the next lane to fill.
  - acc holds lanes 0..RATIO-2.
  - A single output register holds the emitted word.
- s_ready = !rst && (!m_valid || m_ready), identical on every beat. Back-to-back accepts at full rate are allowed while the output drains.
- On an accepted beat with cnt < RATIO-1 and s_last=0:
  - acc lane cnt <= s_data.
  - cnt <= cnt+1.
  - No output change except the m_ready drain below.
- On an accepted beat with cnt == RATIO-1, or with s_last=1 (close condition):
  - Output register <= acc lanes 0..cnt-1, with s_data in lane cnt, and lanes above cnt forced to 0.
  - m_keep <= lanes 0..cnt set (value (1<<(cnt+1))-1).
  - m_last <= s_last; m_valid <= 1.
  - cnt <= 0 and acc cleared to 0.
- Latency: the word is valid on the cycle after its closing beat is accepted.
- Drain: if m_valid && m_ready and no close occurs this cycle, m_valid <= 0. The data/keep/last registers keep their previous values.
- Simultaneous drain and close: the new word replaces the old one and m_valid stays 1 with no bubble.
- cnt wraps to 0 only on close. It never exceeds RATIO-1.
- s_last on the first beat (cnt=0) emits a single-lane word (m_keep=...0001).
- Messages never share an output word.
- m_keep is never 0 while m_valid=1.
- Beat order is preserved: the earliest accepted beat lands in lane 0.

Test Plan:
- IW=32, RATIO=4; feed 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th), m_ready=1 -> one cycle after the 4th accept: m_data=0x44444444_33333333_22222222_11111111, m_keep=0xF, m_last=1.
- Feed 0xA, 0xB with last on 0xB -> m_data=0x00000000_00000000_0000000B_0000000A, m_keep=0x3, m_last=1; the next message starts at lane 0.
- Single beat 0xDEADBEEF with last -> m_keep=0x1, m_data lane 0 = 0xDEADBEEF, upper lanes 0.
- Continuous s_valid of 8 beats (no last until the 8th), m_ready=0 for 5 cycles after the first word -> s_ready=0 once the 4th beat completes; word 1 is held stable; after m_ready=1, word 2 follows immediately with m_last=1; no beat is lost or duplicated.
- Full rate: s_valid=1 and m_ready=1 continuously over 12 beats -> s_ready stays 1; 3 words with m_keep=0xF.
- Assert rst after 2 beats of a message, then feed 4 fresh beats -> the partial beats are discarded and the output word holds only the 4 new beats; all outputs are 0 immediately after reset.
